// File: rtl/muldiv_if.sv
// Issue/response bundle between the execute datapath (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_if #(
   parameter int unsigned XLEN = 32
);
   logic            MD_start;
   logic [2:0]      MD_funct3;
   logic [XLEN-1:0] MD_rs1_data;
   logic [XLEN-1:0] MD_rs2_data;
   logic            MD_busy;
   logic            MD_done;
   logic [XLEN-1:0] MD_result;

   modport master (
      output MD_start, MD_funct3, MD_rs1_data, MD_rs2_data,
      input  MD_busy, MD_done, MD_result
   );

   modport slave (
      input  MD_start, MD_funct3, MD_rs1_data, MD_rs2_data,
      output MD_busy, MD_done, MD_result
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per clock, sign fixed up on the final iteration.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic     SYS_clk,
   input logic     SYS_reset,
   muldiv_if.slave md
);
   localparam int unsigned CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q;
   logic [CW-1:0]     count_q;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   opnd_q;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              neg_q, a_neg_q;
   logic              busy_q, done_q;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sgn_a, sgn_b, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   spec_result;
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN-1:0]   div_diff, quo, rem;
   logic [2*XLEN-1:0] prod_fix;

   // Operand decode at the accept edge: signedness, magnitudes, special cases
   always_comb begin
      sgn_a    = md.MD_funct3[2] ? ~md.MD_funct3[0] : (md.MD_funct3[1:0] != 2'b11);
      sgn_b    = md.MD_funct3[2] ? ~md.MD_funct3[0] : ~md.MD_funct3[1];
      a_neg    = sgn_a & md.MD_rs1_data[XLEN-1];
      b_neg    = sgn_b & md.MD_rs2_data[XLEN-1];
      a_mag    = a_neg ? -md.MD_rs1_data : md.MD_rs1_data;
      b_mag    = b_neg ? -md.MD_rs2_data : md.MD_rs2_data;
      div_zero = md.MD_funct3[2] & (md.MD_rs2_data == '0);
      div_ovf  = md.MD_funct3[2] & ~md.MD_funct3[0] &
                 (md.MD_rs1_data == MIN_NEG) & (md.MD_rs2_data == '1);
      special  = div_zero | div_ovf;
      if (div_zero) spec_result = md.MD_funct3[1] ? md.MD_rs1_data : '1;
      else          spec_result = md.MD_funct3[1] ? '0 : md.MD_rs1_data;
   end

   // One iteration: acc holds {hi, lo} = {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      acc_d     = acc_q;
      mul_sum   = '0;
      div_shift = '0;
      div_diff  = '0;
      if (!op_q[2]) begin
         mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
         acc_d   = {mul_sum, acc_q[XLEN-1:1]};
      end else begin
         div_shift = acc_q[2*XLEN-1:XLEN-1];
         div_diff  = div_shift[XLEN-1:0] - opnd_q;
         if (div_shift >= {1'b0, opnd_q}) acc_d = {div_diff, acc_q[XLEN-2:0], 1'b1};
         else                             acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end

      prod_fix = neg_q ? -acc_d : acc_d;
      quo      = acc_d[XLEN-1:0];
      rem      = acc_d[2*XLEN-1:XLEN];
      if (!op_q[2])   result_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      else if (op_q[1]) result_d = a_neg_q ? -rem : rem;
      else            result_d = neg_q ? -quo : quo;
   end

   always_ff @(posedge SYS_clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (md.MD_start) begin
                  op_q    <= md.MD_funct3;
                  count_q <= CW'(XLEN);
                  neg_q   <= a_neg ^ b_neg;
                  a_neg_q <= a_neg;
                  opnd_q  <= md.MD_funct3[2] ? b_mag : a_mag;
                  acc_q   <= {{XLEN{1'b0}}, (md.MD_funct3[2] ? a_mag : b_mag)};
                  if (special) begin
                     result_q <= spec_result;
                     state_q  <= S_DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            S_RUN: begin
               acc_q   <= acc_d;
               count_q <= count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  result_q <= result_d;
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign md.MD_busy   = busy_q;
   assign md.MD_done   = done_q;
   assign md.MD_result = result_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that executes the eight M-extension operations (`mul`, `mulh`, `mulhsu`, `mulhu`, `div`, `divu`, `rem`, `remu`) over multiple cycles, one bit per clock. It sits directly downstream of the decode/execute datapath and replaces its single-cycle `*`, `/` and `%` operators. The datapath issues operands with a start pulse, stalls the PC while `MD_busy` is high, and writes `MD_result` to `rd` on `MD_done`.

## Interface
- `XLEN`, default 32: operand and result width; iteration count equals `XLEN`.
- `SYS_clk`  in  1  system clock; all state changes on the rising edge.
- `SYS_reset`  in  1  asynchronous, active-high reset.
- `MD_start`  in  1  request; sampled only in IDLE or DONE.
- `MD_funct3`  in  3  operation select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `MD_rs1_data`  in  XLEN  operand a (dividend / multiplicand).
- `MD_rs2_data`  in  XLEN  operand b (divisor / multiplier).
- `MD_busy`  out  1  high in RUN.
- `MD_done`  out  1  one-cycle pulse, high in DONE.
- `MD_result`  out  XLEN  result; valid when `MD_done` is high; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE. `MD_busy` = (state == RUN). `MD_done` = (state == DONE).
- Accept: at an edge where state is IDLE or DONE and `MD_start` = 1, the unit latches funct3, the operand magnitudes, the sign flags and `count` = XLEN.
  - Signed operands: rs1 for mul/mulh/mulhsu/div/rem; rs2 for mul/mulh/div/rem.
  - Unsigned operands use the raw value as the magnitude.
- Special cases resolve at accept and go straight to DONE:
  - div/divu with b = 0: quotient = all ones.
  - rem/remu with b = 0: remainder = a.
  - div with a = 0x80000000 and b = 0xFFFFFFFF: quotient = 0x80000000.
  - rem with a = 0x80000000 and b = 0xFFFFFFFF: remainder = 0.
- Multiply: shift-add on magnitudes into a 2·XLEN product register, one multiplier bit per RUN cycle.
  - The product is negated when the sign flags differ.
  - mul returns the low XLEN bits; mulh, mulhsu and mulhu return the high XLEN bits.
- Divide: restoring division on magnitudes, one quotient bit per RUN cycle.
  - The quotient is negated if the sign flags differ (signed ops only).
  - The remainder takes the sign of a.
- RUN: each edge performs one iteration and decrements `count`. On the edge that completes the last iteration (`count` 1→0), the sign-corrected result is registered into `MD_result` and state goes to DONE.
- DONE: lasts one cycle, then returns to IDLE. If `MD_start` = 1 in DONE, the new operation is accepted at that edge (back-to-back issue).
- `MD_start` during RUN is ignored; no queuing.
- Operand and funct3 inputs are don't-care except at the accept edge.

## Timing
- Reset (async, any state, including mid-RUN): state = IDLE, `MD_busy` = 0, `MD_done` = 0, `MD_result` = 0, `count` = 0, internal accumulators = 0. The in-flight operation is discarded.
- After reset deassertion, the first accept can occur at the next rising edge.
- Normal latency: accept at edge E0, then RUN during cycles E0..E32. `MD_done` = 1 with a valid result in the cycle after E32, i.e. 32 cycles after accept for XLEN = 32.
- Special-case latency: accept at E0, `MD_done` = 1 in the cycle after E0.
- Back-to-back issue: throughput is one operation per 33 cycles (normal) or per 1 cycle (special cases).
- `MD_result` changes only at the edge entering DONE and at reset; it is stable through IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- mul, a = 7, b = 0xFFFFFFFD (−3) → `MD_busy` high for 32 cycles, then a single `MD_done` pulse with `MD_result` = 0xFFFFFFEB.
- High-half multiplies:
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide and remainder:
  - div 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - rem −7 % 2 → 0xFFFFFFFF.
  - divu 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - remu 100 % 7 → 2.
- Special cases, each with `MD_done` one cycle after accept and `MD_busy` never high:
  - div 5 / 0 → 0xFFFFFFFF; rem 5 % 0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem of the same operands → 0.
- Protocol:
  - Start held high through RUN with changing operands → only the first operation executes; result unchanged by the later inputs.
  - Start asserted in DONE → the next operation is accepted with no IDLE gap.
- Reset asserted asynchronously at cycle 10 of a div → outputs clear immediately, state IDLE, no `MD_done`. A subsequent mul 3 × 4 → 12 after 32 cycles.
